// File: rtl/seg7_byte_display_pkg.sv
// Shared types and constants for the byte-to-decimal 7-segment display slice.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BCD_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Decimal digits only; anything above 9 renders blank.
  function automatic logic [6:0] dec_glyph(input logic [NIB_W-1:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'd0: seg = GLYPH_0;
      4'd1: seg = GLYPH_1;
      4'd2: seg = GLYPH_2;
      4'd3: seg = GLYPH_3;
      4'd4: seg = GLYPH_4;
      4'd5: seg = GLYPH_5;
      4'd6: seg = GLYPH_6;
      4'd7: seg = GLYPH_7;
      4'd8: seg = GLYPH_8;
      4'd9: seg = GLYPH_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [NIB_W-1:0] nib);
    logic [6:0] seg;
    seg = dec_glyph(nib);
    case (nib)
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: ;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_byte_display_if.sv
// Byte input from the system bus and the scanned display outputs.
interface seg7_byte_display_if;

  logic [seg7_pkg::BYTE_W-1:0] in_byte;
  logic                        in_byte_en;
  logic [7:0]                  Anode_on;
  logic [6:0]                  Led_output;
  logic                        busy;

  modport master (
    output in_byte, in_byte_en,
    input  Anode_on, Led_output, busy
  );

  modport slave (
    input  in_byte, in_byte_en,
    output Anode_on, Led_output, busy
  );

endinterface

// File: rtl/seg7_byte_display_bin2bcd_seq.sv
// Sequential double-dabble: one adjust+shift per cycle, BYTE_W cycles per conversion.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  logic              active;
  logic [2:0]        cnt;
  logic [BYTE_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BCD_W / NIB_W; i++) begin
      if (bcd_q[i*NIB_W +: NIB_W] >= 4'd5)
        bcd_adj[i*NIB_W +: NIB_W] = bcd_q[i*NIB_W +: NIB_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= '0;
      bin_q  <= bin_in;
      bcd_q  <= '0;
    end else if (active) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt            <= cnt + 3'd1;
      if (cnt == 3'd7)
        active <= 1'b0;
    end
  end

  // done marks the cycle of the final shift; bcd holds the result from the next cycle on.
  assign busy = active;
  assign done = active && (cnt == 3'd7);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_byte_display.sv
// Shows the last written byte in decimal on a scanned 8-digit 7-segment display.
// Define SEG7_HEX_VIEW_EN to also show the byte in hex on digits 5 and 4.
module seg7_byte_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
)
(
  input  logic                clk,
  input  logic                reset,
  seg7_byte_display_if.slave  bus
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state;
  state_t            state_next;
  logic              start;
  logic              capture;
  logic              seen;
  logic [BYTE_W-1:0] cap_byte;
  logic [BYTE_W-1:0] disp_byte;
  logic [NIB_W-1:0]  ones;
  logic [NIB_W-1:0]  tens;
  logic [NIB_W-1:0]  huns;

  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  logic [CNT_W-1:0]  scan_cnt;
  logic              scan_tc;
  logic [2:0]        idx;
  logic [2:0]        idx_next;
  logic [7:0]        anode_q;
  logic [6:0]        led_q;
  logic [6:0]        seg_next;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (reset),
    .start  (start),
    .bin_in (bus.in_byte),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  assign capture = bus.in_byte_en && !conv_busy &&
                   ((bus.in_byte != disp_byte) || !seen);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture) begin
          start      = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: if (conv_done) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      seen      <= 1'b0;
      cap_byte  <= '0;
      disp_byte <= '0;
      ones      <= '0;
      tens      <= '0;
      huns      <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        seen     <= 1'b1;
        cap_byte <= bus.in_byte;
      end
      if (state == ST_LOAD) begin
        disp_byte <= cap_byte;
        ones      <= conv_bcd[0*NIB_W +: NIB_W];
        tens      <= conv_bcd[1*NIB_W +: NIB_W];
        huns      <= conv_bcd[2*NIB_W +: NIB_W];
      end
    end
  end

  assign scan_tc  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_next = scan_tc ? idx + 3'd1 : idx;

  always_comb begin
    seg_next = SEG_BLANK;
    case (idx_next)
      3'd0: seg_next = dec_glyph(ones);
      3'd1: if (huns != '0 || tens != '0) seg_next = dec_glyph(tens);
      3'd2: if (huns != '0) seg_next = dec_glyph(huns);
`ifdef SEG7_HEX_VIEW_EN
      3'd4: seg_next = hex_glyph(disp_byte[3:0]);
      3'd5: seg_next = hex_glyph(disp_byte[7:4]);
`endif
      default: seg_next = SEG_BLANK;
    endcase
  end

  // Segments are decoded from the upcoming digit index so anode and segments switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      anode_q  <= 8'hFE;
      led_q    <= GLYPH_0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
      anode_q  <= ~(8'b1 << idx_next);
      led_q    <= seg_next;
    end
  end

  assign bus.Anode_on   = anode_q;
  assign bus.Led_output = led_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_seg7_byte_display.sv
// Directed bench for seg7_byte_display with a short scan period.
module tb_seg7_byte_display;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  seg7_byte_display_if bus ();

  seg7_byte_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic check_digit(input string tag, input logic [7:0] an, input logic [6:0] seg);
    int unsigned k = 0;
    while (bus.Anode_on !== an && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.Anode_on !== an) check({tag, " anode"}, bus.Anode_on, an);
    else check(tag, bus.Led_output, seg);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k = 0;
    while (bus.busy === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle"}, bus.busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic convert(input string tag, input logic [7:0] b);
    bus.in_byte    = b;
    bus.in_byte_en = 1'b1;
    @(negedge clk);
    check({tag, " busy"}, bus.busy, 1'b1);
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  seq [9];
    logic [7:0]  cur;
    logic        saw;
    int unsigned n;

    seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    bus.in_byte    = 8'd0;
    bus.in_byte_en = 1'b0;

    // Reset asserted between edges takes effect without a clock edge
    #3 reset = 1'b1;
    #1;
    check("rst anode", bus.Anode_on, 8'hFE);
    check("rst led", bus.Led_output, 7'h40);
    check("rst busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // First capture happens even when the byte equals the reset display value
    convert("zero", 8'd0);
    check_digit("zero d0", 8'hFE, 7'h40);
    check_digit("zero d1", 8'hFD, 7'h7F);

    // 255: busy must last exactly 9 cycles
    bus.in_byte    = 8'd255;
    bus.in_byte_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy len", n, 9);
    @(negedge clk);
    check_digit("255 d2", 8'hFB, 7'h24);
    check_digit("255 d1", 8'hFD, 7'h12);
    check_digit("255 d0", 8'hFE, 7'h12);

    convert("7", 8'd7);
    check_digit("7 d2", 8'hFB, 7'h7F);
    check_digit("7 d1", 8'hFD, 7'h7F);
    check_digit("7 d0", 8'hFE, 7'h78);

    convert("100", 8'd100);
    check_digit("100 d2", 8'hFB, 7'h79);
    check_digit("100 d1", 8'hFD, 7'h40);
    check_digit("100 d0", 8'hFE, 7'h40);

    // Enable low: no conversion, display holds
    bus.in_byte_en = 1'b0;
    bus.in_byte    = 8'd55;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | bus.busy;
    end
    check("hold busy", saw, 1'b0);
    check_digit("hold d2", 8'hFB, 7'h79);

    // Same byte re-presented: no new conversion
    bus.in_byte    = 8'd100;
    bus.in_byte_en = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | bus.busy;
    end
    check("same busy", saw, 1'b0);

    // Scan order and dwell
    n = 0;
    while (bus.Anode_on !== 8'h7F && n < 64) begin @(negedge clk); n++; end
    while (bus.Anode_on === 8'h7F && n < 64) begin @(negedge clk); n++; end
    for (int i = 0; i < 9; i++) begin
      check($sformatf("scan%0d", i), bus.Anode_on, seq[i]);
      if (i < 8) begin
        cur = bus.Anode_on;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (bus.Anode_on === cur && n < 10);
        check($sformatf("dwell%0d", i), n, 4);
      end
    end

    // Byte changes mid-conversion: 9 completes, 10 follows after one idle cycle
    bus.in_byte = 8'd9;
    @(negedge clk);
    check("chg busy", bus.busy, 1'b1);
    repeat (2) @(negedge clk);
    bus.in_byte = 8'd10;
    repeat (7) @(negedge clk);
    check("chg gap", bus.busy, 1'b0);
    @(negedge clk);
    check("chg restart", bus.busy, 1'b1);
    wait_idle("chg");
    check_digit("10 d2", 8'hFB, 7'h7F);
    check_digit("10 d1", 8'hFD, 7'h79);
    check_digit("10 d0", 8'hFE, 7'h40);

    // Reset in the middle of a conversion, then exact reload latency
    bus.in_byte = 8'd200;
    @(negedge clk);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst anode", bus.Anode_on, 8'hFE);
    check("midrst led", bus.Led_output, 7'h40);
    check("midrst busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("200 busy", bus.busy, 1'b0);
    check("200 anode", bus.Anode_on, 8'hFB);
    check("200 old", bus.Led_output, 7'h7F);
    @(negedge clk);
    check("200 latency", bus.Led_output, 7'h24);
    check_digit("200 d1", 8'hFD, 7'h40);
    check_digit("200 d0", 8'hFE, 7'h40);

    convert("AF", 8'hAF);
    check_digit("AF d2", 8'hFB, 7'h79);
    check_digit("AF d1", 8'hFD, 7'h78);
    check_digit("AF d0", 8'hFE, 7'h12);
    check_digit("AF d3", 8'hF7, 7'h7F);
`ifdef SEG7_HEX_VIEW_EN
    check_digit("AF d4", 8'hEF, 7'h0E);
    check_digit("AF d5", 8'hDF, 7'h08);
`else
    check_digit("AF d4", 8'hEF, 7'h7F);
    check_digit("AF d5", 8'hDF, 7'h7F);
`endif
    check_digit("AF d6", 8'hBF, 7'h7F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
